pong_game_ctrl: RTL

//   Game-level sequencer for the pong object datapath.
//   - Runs start, countdown, rally and game-over phases.
//   - Keeps both players' scores; holds the ball during countdowns; pulses the

---
 rtl/pong_game_ctrl.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: start/countdown/rally/game-over, scores, serve, winner; PONG_CTRL_SPEEDUP_EN adds ball speed-up.
// Latency: every output registered, an input sampled at edge N shows after edge N.
// Backpressure: none; event pulses are consumed in the cycle they arrive or ignored.
module pong_game_ctrl #(
  parameter int CLK_FRQ        = 100_000_000,
  parameter int CD_TICKS       = CLK_FRQ,
  parameter int WIN_SCORE      = 7,
  parameter int HITS_PER_LEVEL = 4,
  parameter int MAX_SPEED      = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_start,
  input  logic       point_left,
  input  logic       point_right,
  input  logic       paddle_hit,
  output logic       game_active,
  output logic       ball_hold,
  output logic       obj_reset,
  output logic [1:0] countdown,
  output logic [3:0] score_left,
  output logic [3:0] score_right,
  output logic [1:0] winner,
  output logic       serve_dir,
  output logic [1:0] ball_speed
);

  localparam int TW = (CD_TICKS > 1) ? $clog2(CD_TICKS) : 1;

  typedef enum logic [1:0] {IDLE, COUNT, PLAY, GAME_OVER} state_t;

  state_t          state, state_nx;
  logic            btn_q;
  logic [TW-1:0]   timer, timer_nx;
  logic            game_active_nx, ball_hold_nx, obj_reset_nx, serve_dir_nx;
  logic [1:0]      countdown_nx, winner_nx, ball_speed_nx;
  logic [3:0]      score_left_nx, score_right_nx;

  logic start_evt, timer_wrap, pt_l, pt_r, left_win, right_win, enter_count;

  assign start_evt  = btn_start & ~btn_q;
  assign timer_wrap = (timer == TW'(CD_TICKS - 1));
  assign pt_l       = point_left & ~point_right;
  assign pt_r       = point_right & ~point_left;
  assign left_win   = ((score_left + 4'd1) == 4'(WIN_SCORE));
  assign right_win  = ((score_right + 4'd1) == 4'(WIN_SCORE));
  assign enter_count = (state_nx == COUNT) && (state != COUNT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      btn_q       <= 1'b0;
      timer       <= '0;
      game_active <= 1'b0;
      ball_hold   <= 1'b1;
      obj_reset   <= 1'b0;
      countdown   <= 2'd0;
      score_left  <= 4'd0;
      score_right <= 4'd0;
      winner      <= 2'b00;
      serve_dir   <= 1'b1;
      ball_speed  <= 2'd1;
    end else begin
      state       <= state_nx;
      btn_q       <= btn_start;
      timer       <= timer_nx;
      game_active <= game_active_nx;
      ball_hold   <= ball_hold_nx;
      obj_reset   <= obj_reset_nx;
      countdown   <= countdown_nx;
      score_left  <= score_left_nx;
      score_right <= score_right_nx;
      winner      <= winner_nx;
      serve_dir   <= serve_dir_nx;
      ball_speed  <= ball_speed_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE, GAME_OVER: if (start_evt) state_nx = COUNT;
      COUNT:           if (timer_wrap && countdown == 2'd1) state_nx = PLAY;
      PLAY: begin
        if ((pt_l && left_win) || (pt_r && right_win)) state_nx = GAME_OVER;
        else if (point_left || point_right)            state_nx = COUNT;
      end
      default:         state_nx = IDLE;
    endcase
  end

  always_comb begin
    timer_nx       = timer;
    obj_reset_nx   = 1'b0;
    countdown_nx   = countdown;
    score_left_nx  = score_left;
    score_right_nx = score_right;
    winner_nx      = winner;
    serve_dir_nx   = serve_dir;
    case (state)
      IDLE, GAME_OVER: begin
        if (start_evt) begin
          score_left_nx  = 4'd0;
          score_right_nx = 4'd0;
          winner_nx      = 2'b00;
        end
      end
      COUNT: begin
        timer_nx = timer_wrap ? '0 : timer + 1'b1;
        if (timer_wrap) countdown_nx = countdown - 2'd1;
      end
      PLAY: begin
        if (pt_l) begin
          score_left_nx = score_left + 4'd1;
          serve_dir_nx  = 1'b1;
          if (left_win) winner_nx = 2'b01;
        end else if (pt_r) begin
          score_right_nx = score_right + 4'd1;
          serve_dir_nx   = 1'b0;
          if (right_win) winner_nx = 2'b10;
        end
      end
      default: ;
    endcase
    // Every way into COUNT (start, scored point, replayed rally) re-centres and restarts the digits.
    if (enter_count) begin
      obj_reset_nx = 1'b1;
      countdown_nx = 2'd3;
      timer_nx     = '0;
    end
    game_active_nx = (state_nx == COUNT) || (state_nx == PLAY);
    ball_hold_nx   = (state_nx != PLAY);
  end

`ifdef PONG_CTRL_SPEEDUP_EN
  localparam int HW = (HITS_PER_LEVEL > 1) ? $clog2(HITS_PER_LEVEL) : 1;

  logic [HW-1:0] hit_cnt, hit_cnt_nx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) hit_cnt <= '0;
    else       hit_cnt <= hit_cnt_nx;
  end

  always_comb begin
    hit_cnt_nx    = hit_cnt;
    ball_speed_nx = ball_speed;
    if (enter_count) begin
      hit_cnt_nx    = '0;
      ball_speed_nx = 2'd1;
    end else if (state == PLAY && paddle_hit) begin
      if (hit_cnt == HW'(HITS_PER_LEVEL - 1)) begin
        hit_cnt_nx = '0;
        if (ball_speed < 2'(MAX_SPEED)) ball_speed_nx = ball_speed + 2'd1;
      end else begin
        hit_cnt_nx = hit_cnt + 1'b1;
      end
    end
  end
`else
  logic unused_speedup;
  assign unused_speedup = ^{paddle_hit, HITS_PER_LEVEL[0], MAX_SPEED[0]};
  assign ball_speed_nx  = 2'd1;
`endif

endmodule
